// File: rtl/project_pkg.sv
// Shared types and constants for the matrix front end: matrix container,
// dimension/value limits, parser error codes and ASCII token characters.
package project_pkg;

  localparam int SYS_CLK_FREQ    = 100_000_000;
  localparam int MAX_ROWS        = 4;
  localparam int MAX_COLS        = 4;
  localparam int DIM_W           = 3;
  localparam int ELEM_W          = 8;
  localparam int DEFAULT_VAL_MIN = -2;
  localparam int DEFAULT_VAL_MAX = 9;

  typedef struct packed {
    logic                                         is_valid;
    logic [DIM_W-1:0]                             rows;
    logic [DIM_W-1:0]                             cols;
    logic [MAX_ROWS-1:0][MAX_COLS-1:0][ELEM_W-1:0] cells;
  } matrix_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_DIM   = 2'd1,
    ERR_RANGE = 2'd2,
    ERR_CHAR  = 2'd3
  } parse_err_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;

  function automatic logic is_sep_char(input logic [7:0] b);
    return (b == ASCII_SPACE) || (b == ASCII_CR) || (b == ASCII_LF);
  endfunction

endpackage

// File: rtl/matrix_input_parser_ascii_num_accum.sv
// Token accumulator: optional leading '-', saturating decimal magnitude,
// token-done strobe on the terminating separator, and token syntax errors.
module ascii_num_accum
  import project_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       byte_vld,
  input  logic [7:0] rx_byte,
  output logic [7:0] acc,
  output logic       neg,
  output logic       tok_done,
  output logic       fmt_err
);

  logic        in_tok;
  logic        has_digit;
  logic        is_digit;
  logic        is_minus;
  logic        is_sep;
  logic [11:0] acc_mul;

  assign is_digit = (rx_byte >= ASCII_0) && (rx_byte <= ASCII_9);
  assign is_minus = (rx_byte == ASCII_MINUS);
  assign is_sep   = is_sep_char(rx_byte);
  assign acc_mul  = 12'(acc) * 12'd10 + 12'(rx_byte - ASCII_0);

  // A lone '-' closed by a separator is malformed, so done needs a digit.
  assign tok_done = byte_vld && is_sep && has_digit;
  assign fmt_err  = byte_vld && (
                      !(is_digit || is_minus || is_sep) ||
                      (is_minus && in_tok) ||
                      (is_sep && in_tok && !has_digit));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc       <= '0;
      neg       <= 1'b0;
      in_tok    <= 1'b0;
      has_digit <= 1'b0;
    end else if (byte_vld) begin
      if (is_digit) begin
        acc       <= (acc_mul > 12'd255) ? 8'hFF : acc_mul[7:0];
        in_tok    <= 1'b1;
        has_digit <= 1'b1;
      end else if (is_minus && !in_tok) begin
        neg    <= 1'b1;
        in_tok <= 1'b1;
      end else if (tok_done) begin
        acc       <= '0;
        neg       <= 1'b0;
        in_tok    <= 1'b0;
        has_digit <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/matrix_input_parser.sv
// Parses an ASCII "rows cols e0 e1 ..." stream from the UART into a matrix_t,
// one byte per cycle, reporting completion or the first error as a pulse.
module matrix_input_parser
  import project_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output matrix_t    mat_out,
  output logic       mat_valid,
  output logic       err,
  output logic [1:0] err_code,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, GET_ROWS, GET_COLS, GET_ELEM, FAIL} state_t;

  localparam int               RIW      = $clog2(MAX_ROWS);
  localparam int               CIW      = $clog2(MAX_COLS);
  localparam logic [7:0]       ROWS_LIM = 8'(MAX_ROWS);
  localparam logic [7:0]       COLS_LIM = 8'(MAX_COLS);
  localparam logic signed [9:0] VAL_LO  = 10'(DEFAULT_VAL_MIN);
  localparam logic signed [9:0] VAL_HI  = 10'(DEFAULT_VAL_MAX);

  state_t            state, state_nxt;
  parse_err_t        err_nxt, err_code_q;
  logic              parsing, byte_ok, tok_done, fmt_err, neg;
  logic              dim_bad, last_elem, done_nxt;
  logic [7:0]        acc, rows_acc;
  logic              rows_neg;
  logic [RIW-1:0]    erow;
  logic [CIW-1:0]    ecol;
  logic signed [9:0] mag, elem_val;

  assign parsing = (state == GET_ROWS) || (state == GET_COLS) || (state == GET_ELEM);
  // start and abort both swallow any byte arriving in the same cycle
  assign byte_ok = rx_valid && parsing && !start && !abort;

  ascii_num_accum u_accum (
    .clk      (clk),
    .rst      (rst),
    .clr      (start || abort),
    .byte_vld (byte_ok),
    .rx_byte  (rx_data),
    .acc      (acc),
    .neg      (neg),
    .tok_done (tok_done),
    .fmt_err  (fmt_err)
  );

  assign mag      = $signed({2'b00, acc});
  assign elem_val = neg ? -mag : mag;

  // Rows is only held while cols arrives; both dimensions are judged together.
  assign dim_bad = rows_neg || (rows_acc == 8'd0) || (rows_acc > ROWS_LIM) ||
                   neg || (acc == 8'd0) || (acc > COLS_LIM);

  assign last_elem = (DIM_W'(erow) == mat_out.rows - DIM_W'(1)) &&
                     (DIM_W'(ecol) == mat_out.cols - DIM_W'(1));

  always_comb begin
    err_nxt = ERR_NONE;
    if (fmt_err) begin
      err_nxt = ERR_CHAR;
    end else if (tok_done) begin
      case (state)
        GET_COLS: if (dim_bad) err_nxt = ERR_DIM;
        GET_ELEM: if ((elem_val < VAL_LO) || (elem_val > VAL_HI)) err_nxt = ERR_RANGE;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = GET_ROWS;
    end else if (abort) begin
      state_nxt = IDLE;
    end else if (err_nxt != ERR_NONE) begin
      state_nxt = FAIL;
    end else if (tok_done) begin
      case (state)
        GET_ROWS: state_nxt = GET_COLS;
        GET_COLS: state_nxt = GET_ELEM;
        GET_ELEM: if (last_elem) state_nxt = IDLE;
        default:  ;
      endcase
    end
  end

  always_comb begin
    busy     = parsing;
    done_nxt = tok_done && (state == GET_ELEM) && last_elem && (err_nxt == ERR_NONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mat_out    <= '0;
      mat_valid  <= 1'b0;
      err        <= 1'b0;
      err_code_q <= ERR_NONE;
      rows_acc   <= '0;
      rows_neg   <= 1'b0;
      erow       <= '0;
      ecol       <= '0;
    end else begin
      mat_valid <= done_nxt;
      err       <= (err_nxt != ERR_NONE);
      if (start) begin
        mat_out    <= '0;
        err_code_q <= ERR_NONE;
        rows_acc   <= '0;
        rows_neg   <= 1'b0;
        erow       <= '0;
        ecol       <= '0;
      end else if (err_nxt != ERR_NONE) begin
        err_code_q <= err_nxt;
      end else if (tok_done) begin
        case (state)
          GET_ROWS: begin
            rows_acc <= acc;
            rows_neg <= neg;
          end
          GET_COLS: begin
            mat_out.rows <= rows_acc[DIM_W-1:0];
            mat_out.cols <= acc[DIM_W-1:0];
          end
          GET_ELEM: begin
            mat_out.cells[erow][ecol] <= elem_val[ELEM_W-1:0];
            if (last_elem) begin
              mat_out.is_valid <= 1'b1;
            end else if (DIM_W'(ecol) == mat_out.cols - DIM_W'(1)) begin
              ecol <= '0;
              erow <= erow + RIW'(1);
            end else begin
              ecol <= ecol + CIW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign err_code = err_code_q;

endmodule

// File: doc/matrix_input_parser.md
MATRIX_INPUT_PARSER -- requirements
Module: matrix_input_parser

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk  input  1  system clock, 100 MHz (SYS_CLK_FREQ).
REQ-002 rst  input  1  synchronous active-high reset.
REQ-003 start  input  1  one-cycle pulse; arms the parser for a new matrix.
REQ-004 abort  input  1  one-cycle pulse; discards the parse in progress.
REQ-005 rx_data  input  8  ASCII byte from the UART receiver.
REQ-006 rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-007 mat_out  output  matrix_t  parsed matrix; held stable from mat_valid until the next start.
REQ-008 mat_valid  output  1  one-cycle pulse, mat_out complete.
REQ-009 err  output  1  one-cycle pulse, parse failed.
REQ-010 err_code  output  2  cause of error; held until the next start.
REQ-011 busy  output  1  high from start until done, error, or abort.

Function
REQ-012 Input format SHALL be tokens in order: rows, cols, then rows*cols elements in row-major order; each token is an optional '-' followed by decimal digits.
REQ-013 Separators SHALL be 0x20, 0x0D and 0x0A; consecutive separators SHALL collapse into one; a token SHALL end only on a separator.
REQ-014 The FSM states SHALL be IDLE, GET_ROWS, GET_COLS, GET_ELEM and FAIL; rx_valid SHALL be ignored in IDLE.
REQ-015 start SHALL move the FSM to GET_ROWS from any state, clear mat_out to zero, clear err_code, and reset the token accumulator and the element index.
REQ-016 Digit accumulation SHALL be acc = acc*10 + digit, with acc saturating at 255.
REQ-017 A rows or cols token outside 1..MAX_ROWS/MAX_COLS, or carrying '-', SHALL raise ERR_DIM (2'd1).
REQ-018 An element outside DEFAULT_VAL_MIN..DEFAULT_VAL_MAX after sign is applied SHALL raise ERR_RANGE (2'd2).
REQ-019 Any other byte, or '-' that is not the first character of a token, SHALL raise ERR_CHAR (2'd3).
REQ-020 On any error, err SHALL pulse in the cycle after the offending byte, busy SHALL drop, and the FSM SHALL enter FAIL.
REQ-021 FAIL SHALL ignore bytes until start.
REQ-022 Element k SHALL be written to cells[k / cols][k % cols]; cells outside rows x cols SHALL remain 0.
REQ-023 mat_out.rows and mat_out.cols SHALL take the parsed values.
REQ-024 mat_out.is_valid SHALL be set in the same cycle that mat_valid pulses.
REQ-025 mat_valid SHALL pulse exactly one cycle after the rx_valid cycle that carries the separator terminating the last element; the FSM SHALL then return to IDLE and busy SHALL drop in that same cycle.
REQ-026 Bytes after completion SHALL be ignored.
REQ-027 abort SHALL return the FSM to IDLE with no err pulse and no mat_valid pulse.
REQ-028 If start and abort are asserted together, start SHALL win.
REQ-029 If start coincides with rx_valid, the byte SHALL be dropped.
REQ-030 Consecutive rx_valid cycles SHALL be accepted without loss; the block SHALL be fully pipelined at one byte per cycle.

Reset
REQ-031 While reset is asserted: state = IDLE, mat_out = 0 (is_valid = 0), mat_valid = 0, err = 0, err_code = 0, busy = 0, accumulator = 0, sign = 0, index = 0.
REQ-032 Reset SHALL take priority over start, abort and rx_valid.
REQ-033 Reset mid-parse SHALL discard the partial matrix.

Structure
REQ-034 matrix_t, MAX_ROWS, MAX_COLS, DEFAULT_VAL_MIN and DEFAULT_VAL_MAX SHALL come from project_pkg.
REQ-035 A new typedef enum logic [1:0] parse_err_t (ERR_NONE, ERR_DIM, ERR_RANGE, ERR_CHAR) SHALL be added to project_pkg.
REQ-036 ASCII separator constants SHALL be added to project_pkg.
REQ-037 The parser FSM state enum SHALL stay local to the module.
REQ-038 One sub-module, ascii_num_accum, SHALL hold the digit/sign accumulator with saturation and a token-done flag.

Verification
REQ-039 start, "2 3 1 2 3 4 5 6\n" -> mat_valid once; rows=2, cols=3; cells[0]={1,2,3}, cells[1]={4,5,6}; all other cells 0; is_valid=1.
REQ-040 start, "6 2 " -> err one cycle after the second space; err_code=ERR_DIM; busy=0; no mat_valid.
REQ-041 start, "1 2 5 12 " -> err with ERR_RANGE; start, "1 1 -3 " -> err with ERR_RANGE.
REQ-042 start, "1  1\r\n\r\n7\n" (repeated separators, back-to-back rx_valid) -> mat_valid with cells[0][0]=7.
REQ-043 start, "2 2 1 " then abort -> no pulses, busy=0; start, "1 1 4 " -> valid 1x1 matrix containing 4.
REQ-044 Reset asserted between two element bytes -> all outputs at reset values; later bytes ignored until start.
